// File: rtl/frame_capture_sequencer.sv
// Triggers a single-frame store, waits for capture, then drains it as 32-bit valid/ready beats; FRAME_HEADER_EN adds a header beat.
// Latency: last accepted beat to next fs_trigger is gap_cycles+1; out_valid holds until out_ready and drops early only on abort.
module frame_capture_sequencer #(
   parameter int FRAME_WIDTH    = 256,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int FRAME_CNT_W    = 16
) (
   input  logic                   axi_clk,
   input  logic                   axi_reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [FRAME_CNT_W-1:0] num_frames,
   input  logic [31:0]            gap_cycles,
   output logic                   fs_trigger,
   input  logic [31:0]            fs_status,
   input  logic [31:0]            fs_frame_read,
   output logic                   fs_frame_read_rdStrobe,
   output logic [31:0]            out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic                   busy,
   output logic [FRAME_CNT_W-1:0] frames_done,
   output logic                   timeout_err
);

   localparam int NUM_CHUNKS = (FRAME_WIDTH + 31) / 32;
   localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam int TO_W       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);
   localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_WAIT_SET, S_WAIT_DONE, S_HEADER, S_READ, S_GAP
   } state_t;

   state_t                 state, state_nxt;
   logic [FRAME_CNT_W-1:0] frames_n;
   logic [31:0]            gap_n;
   logic [31:0]            gap_cnt;
   logic [TO_W-1:0]        to_cnt;
   logic [CHUNK_W-1:0]     chunk_cnt;
   logic [FRAME_CNT_W:0]   frames_done_p1;

   logic run_ld, to_clr, to_inc, to_hit;
   logic chunk_clr, chunk_inc, frame_inc, gap_clr, gap_inc;

   // Only the triggered/complete bits of the status word carry meaning here.
   logic status_unused;
   assign status_unused = ^fs_status[31:2];

   assign busy           = (state != S_IDLE);
   assign frames_done_p1 = {1'b0, frames_done} + 1'b1;

   always_ff @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset) state <= S_IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt              = state;
      fs_trigger             = 1'b0;
      fs_frame_read_rdStrobe = 1'b0;
      out_valid              = 1'b0;
      out_data               = 32'h0;
      out_last               = 1'b0;
      run_ld                 = 1'b0;
      to_clr                 = 1'b0;
      to_inc                 = 1'b0;
      to_hit                 = 1'b0;
      chunk_clr              = 1'b0;
      chunk_inc              = 1'b0;
      frame_inc              = 1'b0;
      gap_clr                = 1'b0;
      gap_inc                = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               run_ld    = 1'b1;
               state_nxt = S_ARM;
            end
         end
         S_ARM: begin
            fs_trigger = 1'b1;
            to_clr     = 1'b1;
            state_nxt  = S_WAIT_SET;
         end
         S_WAIT_SET: begin
            if (to_cnt == TO_LAST) begin
               to_hit    = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               to_inc = 1'b1;
               if (fs_status[0]) state_nxt = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (to_cnt == TO_LAST) begin
               to_hit    = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               to_inc = 1'b1;
               if (!fs_status[0] && fs_status[1]) begin
                  chunk_clr = 1'b1;
`ifdef FRAME_HEADER_EN
                  state_nxt = S_HEADER;
`else
                  state_nxt = S_READ;
`endif
               end
            end
         end
`ifdef FRAME_HEADER_EN
         S_HEADER: begin
            // Header carries the index of the frame about to be streamed.
            out_valid = 1'b1;
            out_data  = {16'hF5A0, 16'(frames_done)};
            if (out_ready) state_nxt = S_READ;
         end
`endif
         S_READ: begin
            out_valid              = 1'b1;
            out_data               = fs_frame_read;
            out_last               = (chunk_cnt == LAST_CHUNK);
            fs_frame_read_rdStrobe = out_ready;
            if (out_ready) begin
               chunk_inc = 1'b1;
               if (chunk_cnt == LAST_CHUNK) begin
                  frame_inc = 1'b1;
                  if ((frames_n != '0) && (frames_done_p1 == {1'b0, frames_n}))
                     state_nxt = S_IDLE;
                  else if (gap_n == 32'h0)
                     state_nxt = S_ARM;
                  else begin
                     gap_clr   = 1'b1;
                     state_nxt = S_GAP;
                  end
               end
            end
         end
         S_GAP: begin
            if (gap_cnt == gap_n - 32'd1) state_nxt = S_ARM;
            else                          gap_inc   = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
      // Abort overrides everything, including a coincident start or last beat.
      if (abort) begin
         state_nxt = S_IDLE;
         run_ld    = 1'b0;
         to_hit    = 1'b0;
         frame_inc = 1'b0;
      end
   end

   always_ff @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset) begin
         frames_n    <= '0;
         gap_n       <= 32'h0;
         gap_cnt     <= 32'h0;
         to_cnt      <= '0;
         chunk_cnt   <= '0;
         frames_done <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (run_ld) begin
            frames_n    <= num_frames;
            gap_n       <= gap_cycles;
            frames_done <= '0;
            timeout_err <= 1'b0;
         end else if (frame_inc && (frames_done != '1)) begin
            frames_done <= frames_done + 1'b1;
         end
         if (to_hit) timeout_err <= 1'b1;

         if (to_clr)      to_cnt <= '0;
         else if (to_inc) to_cnt <= to_cnt + 1'b1;

         if (chunk_clr)      chunk_cnt <= '0;
         else if (chunk_inc) chunk_cnt <= chunk_cnt + 1'b1;

         if (gap_clr)      gap_cnt <= 32'h0;
         else if (gap_inc) gap_cnt <= gap_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_frame_capture_sequencer.sv
// Directed bench for frame_capture_sequencer: 80-bit frames (3 chunks), 20-cycle capture timeout, behavioural frame store.
// Honours FRAME_HEADER_EN when the same define is given to bench and design.
module tb_frame_capture_sequencer;

   localparam int FW   = 80;
   localparam int NC   = (FW + 31) / 32;
   localparam int TO   = 20;
`ifdef FRAME_HEADER_EN
   localparam int HDR  = 1;
`else
   localparam int HDR  = 0;
`endif
   localparam int FB   = NC + HDR;

   logic        axi_clk;
   logic        axi_reset;
   logic        start, abort;
   logic [15:0] num_frames;
   logic [31:0] gap_cycles;
   logic        fs_trigger;
   logic [31:0] fs_status;
   logic [31:0] fs_frame_read;
   logic        fs_frame_read_rdStrobe;
   logic [31:0] out_data;
   logic        out_valid, out_ready, out_last, busy;
   logic [15:0] frames_done;
   logic        timeout_err;

   frame_capture_sequencer #(.FRAME_WIDTH(FW), .TIMEOUT_CYCLES(TO), .FRAME_CNT_W(16)) dut (
      .axi_clk(axi_clk), .axi_reset(axi_reset), .start(start), .abort(abort),
      .num_frames(num_frames), .gap_cycles(gap_cycles), .fs_trigger(fs_trigger),
      .fs_status(fs_status), .fs_frame_read(fs_frame_read),
      .fs_frame_read_rdStrobe(fs_frame_read_rdStrobe), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy),
      .frames_done(frames_done), .timeout_err(timeout_err)
   );

   initial axi_clk = 1'b0;
   always #5 axi_clk = ~axi_clk;

   int cyc = 0;
   always @(posedge axi_clk) cyc <= cyc + 1;

   // Frame store: re-zeroes its pointer on trigger, raises triggered then complete.
   logic [7:0] cap_n;
   logic [7:0] ptr;
   logic [3:0] st_cnt;
   logic [1:0] st;
   bit         never_set = 1'b0;

   function automatic logic [31:0] store_word(input logic [7:0] n, input int k);
      if (k == NC - 1) return {16'h0000, n, 8'(k)};
      return {8'hC0, 8'(k), n, 8'h5A};
   endfunction

   assign fs_status     = {30'h0, st};
   assign fs_frame_read = store_word(cap_n, int'(ptr));

   always @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset) begin
         cap_n <= 8'h0; ptr <= 8'h0; st_cnt <= 4'h0; st <= 2'b00;
      end else if (fs_trigger) begin
         cap_n <= cap_n + 8'h1; ptr <= 8'h0; st_cnt <= 4'h1; st <= 2'b00;
      end else begin
         if (st_cnt != 4'h0 && st_cnt < 4'h8) st_cnt <= st_cnt + 4'h1;
         if (!never_set && st_cnt == 4'h2) st <= 2'b01;
         if (!never_set && st_cnt == 4'h5) st <= 2'b10;
         if (fs_frame_read_rdStrobe) ptr <= ptr + 8'h1;
      end
   end

   int    n_vec = 0;
   int    n_err = 0;
   string cur_tag = "reset";

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s/%s: got %0h expected %0h", cur_tag, name, act, exp);
      end
   endtask

   typedef struct {
      string       tag;
      logic [15:0] nf;
      logic [31:0] gap;
      bit          rnd;
      bit          poke;
      int          exp;
   } scn_t;

   task automatic run_scn(input scn_t s);
      int beat, frames, trigs, strobes, last_acc;
      bit done, holding, exp_l, exp_s;
      logic [31:0] held_d, exp_d;
      logic        held_l;
      beat = 0; frames = 0; trigs = 0; strobes = 0; last_acc = -1;
      done = 0; holding = 0; held_d = 0; held_l = 0;
      cur_tag = s.tag;
      num_frames = s.nf; gap_cycles = s.gap;
      @(posedge axi_clk); #1; start = 1'b1; out_ready = 1'b0;
      @(posedge axi_clk); #1; start = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         out_ready = s.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start = s.poke && (c == 4);
         if (s.poke && c == 4) num_frames = s.nf + 16'd5;
         @(negedge axi_clk);
         if (c == 0) check("busy_after_start", 32'(busy), 32'd1);
         if (fs_trigger) begin
            trigs++;
            if (last_acc >= 0) check("gap_latency", 32'(cyc - last_acc), s.gap + 32'd1);
         end
         if (holding) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", out_data, held_d);
            check("hold_last", 32'(out_last), 32'(held_l));
         end
         holding = out_valid && !out_ready;
         held_d  = out_data;
         held_l  = out_last;
         if (fs_frame_read_rdStrobe) strobes++;
         if (out_valid && out_ready) begin
            exp_d = (beat < HDR) ? {16'hF5A0, 16'(frames)} : store_word(cap_n, beat - HDR);
            exp_l = (beat == FB - 1);
            exp_s = (beat >= HDR);
            check("beat_data", out_data, exp_d);
            check("beat_last", 32'(out_last), 32'(exp_l));
            check("beat_strobe", 32'(fs_frame_read_rdStrobe), 32'(exp_s));
            if (exp_l) begin
               beat = 0; frames++; last_acc = cyc;
            end else beat++;
         end
         if (!busy) done = 1;
         else begin
            @(posedge axi_clk); #1;
         end
      end
      start = 1'b0;
      check("run_finished", 32'(done), 32'd1);
      check("frames_streamed", 32'(frames), 32'(s.exp));
      check("frames_done", 32'(frames_done), 32'(s.exp));
      check("trigger_count", 32'(trigs), 32'(s.exp));
      check("strobe_count", 32'(strobes), 32'(s.exp * NC));
      check("timeout_err_clear", 32'(timeout_err), 32'd0);
   endtask

   scn_t scns[4];
   int   acc;
   bit   found, saw;
   logic [31:0] hd;

   initial begin
      scns[0] = '{"single",      16'd1, 32'd0,  1'b0, 1'b0, 1};
      scns[1] = '{"three_gap10", 16'd3, 32'd10, 1'b1, 1'b0, 3};
      scns[2] = '{"busy_start",  16'd2, 32'd1,  1'b0, 1'b1, 2};
      scns[3] = '{"two_rand",    16'd2, 32'd0,  1'b1, 1'b0, 2};

      axi_reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      num_frames = 16'd0; gap_cycles = 32'd0;
      repeat (3) @(negedge axi_clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_trigger", 32'(fs_trigger), 32'd0);
      check("rst_strobe", 32'(fs_frame_read_rdStrobe), 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
      check("rst_frames_done", 32'(frames_done), 32'd0);
      check("rst_timeout", 32'(timeout_err), 32'd0);
      @(posedge axi_clk); #1; axi_reset = 1'b0;

      for (int i = 0; i < 4; i++) run_scn(scns[i]);

      // Start and abort together while idle: abort wins.
      cur_tag = "start_abort";
      @(posedge axi_clk); #1; start = 1'b1; abort = 1'b1;
      @(posedge axi_clk); #1; start = 1'b0; abort = 1'b0;
      saw = 0;
      repeat (6) begin
         @(negedge axi_clk);
         if (busy || fs_trigger) saw = 1;
      end
      check("no_activity", 32'(saw), 32'd0);

      // Store never reports triggered: timeout lands 21 cycles after the trigger.
      cur_tag = "timeout";
      never_set = 1; num_frames = 16'd1; gap_cycles = 32'd0; out_ready = 1'b1;
      @(posedge axi_clk); #1; start = 1'b1;
      @(posedge axi_clk); #1; start = 1'b0;
      @(negedge axi_clk);
      check("trigger", 32'(fs_trigger), 32'd1);
      saw = 0;
      for (int i = 1; i <= 21; i++) begin
         @(negedge axi_clk);
         if (out_valid || fs_trigger) saw = 1;
         if (i == 20) begin
            check("err_before", 32'(timeout_err), 32'd0);
            check("busy_before", 32'(busy), 32'd1);
         end
         if (i == 21) begin
            check("err_set", 32'(timeout_err), 32'd1);
            check("idle_after", 32'(busy), 32'd0);
         end
      end
      check("no_valid_or_retrigger", 32'(saw), 32'd0);
      never_set = 0;
      run_scn('{"after_timeout", 16'd1, 32'd0, 1'b0, 1'b0, 1});

      // Continuous run, abort while beat 2 of frame 2 is stalled.
      cur_tag = "abort";
      num_frames = 16'd0; gap_cycles = 32'd0;
      @(posedge axi_clk); #1; start = 1'b1;
      @(posedge axi_clk); #1; start = 1'b0;
      acc = 0; found = 0;
      for (int c = 0; c < 400 && !found; c++) begin
         out_ready = (acc < FB + 1);
         @(negedge axi_clk);
         if (out_valid && out_ready) acc++;
         if (acc == FB + 1 && out_valid && !out_ready) found = 1;
         else begin
            @(posedge axi_clk); #1;
         end
      end
      check("stall_reached", 32'(found), 32'd1);
      hd = out_data;
      @(posedge axi_clk); #1;
      @(negedge axi_clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", out_data, hd);
      @(posedge axi_clk); #1; abort = 1'b1;
      @(posedge axi_clk); #1; abort = 1'b0;
      @(negedge axi_clk);
      check("valid_dropped", 32'(out_valid), 32'd0);
      check("busy_dropped", 32'(busy), 32'd0);
      check("partial_not_counted", 32'(frames_done), 32'd1);
      run_scn('{"restart", 16'd1, 32'd2, 1'b0, 1'b0, 1});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/frame_capture_sequencer.md
Name: frame_capture_sequencer

Overview:
- Single-clock AXI-domain controller that sequences a single-frame capture store through repeated capture and readout cycles.
- Issues the trigger pulse and tracks the store's status word (bit0 = triggered, bit1 = capture complete).
- Drains each captured frame chunk-by-chunk onto a 32-bit valid/ready stream, with programmable frame count, inter-frame gap and capture timeout.

Parameters:
- FRAME_WIDTH, 256, width of the captured frame in bits; NUM_CHUNKS = ceil(FRAME_WIDTH/32).
- TIMEOUT_CYCLES, 65535, max axi_clk cycles spent waiting for capture before error.
- FRAME_CNT_W, 16, width of frame count and frame index.

Ports:
- axi_clk  in  1  clock.
- axi_reset  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a capture run when idle.
- abort  in  1  one-cycle pulse; terminates the run.
- num_frames  in  FRAME_CNT_W  frames per run; 0 = continuous until abort.
- gap_cycles  in  32  idle cycles between end of readout and next trigger.
- fs_trigger  out  1  trigger pulse to the frame store.
- fs_status  in  32  frame-store status word.
- fs_frame_read  in  32  current chunk from the frame store.
- fs_frame_read_rdStrobe  out  1  advances the store's read pointer.
- out_data  out  32  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  marks the final beat of a frame.
- busy  out  1  high in any state other than IDLE.
- frames_done  out  FRAME_CNT_W  frames fully streamed in current/last run.
- timeout_err  out  1  sticky; set on capture timeout, cleared by the next accepted start.

Behaviour:
- Reset (async, axi_reset=1): state IDLE; all outputs 0, including frames_done, timeout_err, and the chunk, gap and timeout counters.
- num_frames and gap_cycles are sampled on the accepted start and held for the run.
- IDLE: on start (and no abort), clear frames_done and timeout_err, then go to ARM. Start while busy is ignored.
- ARM: fs_trigger=1 for exactly one cycle, then go to WAIT_SET; the timeout counter is cleared.
- WAIT_SET: wait for fs_status[0]=1, then go to WAIT_DONE.
- WAIT_DONE: wait for fs_status[0]=0 with fs_status[1]=1, then go to READ with chunk counter 0.
- Timeout: in WAIT_SET/WAIT_DONE the timeout counter increments each cycle. When it reaches TIMEOUT_CYCLES, set timeout_err, go to IDLE, and stop the run.
- READ:
  - out_valid=1; out_data=fs_frame_read, combinational pass-through.
  - out_last=1 when chunk counter = NUM_CHUNKS-1.
  - fs_frame_read_rdStrobe = out_valid & out_ready, in the same cycle as beat acceptance.
  - On an accepted beat the chunk counter increments.
  - On the accepted last beat: frames_done increments and the next state is chosen:
    - if num_frames≠0 and frames_done+1 = num_frames, go to IDLE;
    - else if gap_cycles=0, go to ARM;
    - else go to GAP.
- Stream rules: out_data/out_last are stable while out_valid=1 and out_ready=0. out_valid never drops without acceptance, except on abort.
- GAP: counts gap_cycles cycles (gap_cycles=1 gives one GAP cycle), then go to ARM.
- Abort: from any state, next cycle go to IDLE; out_valid and fs_trigger deassert.
  - An aborted partial frame is not counted.
  - The store's read pointer is left mid-frame; it re-zeroes on the next trigger.
  - Abort and start in the same cycle: abort wins and the start is discarded.
- frames_done saturates at all-ones in continuous mode.
- Frame latency: trigger to first out_valid depends on the store's CDC. Last beat accepted to next fs_trigger = gap_cycles+1 cycles.

Optional Feature:
- Macro FRAME_HEADER_EN.
- Defined: READ is preceded by a HEADER beat.
  - out_data = {16'hF5A0, frame index zero-extended/truncated to 16 bits}, where the index is frames_done before increment.
  - out_last=0; no fs_frame_read_rdStrobe on the header beat.
  - A frame is NUM_CHUNKS+1 beats.
- Undefined: no header; a frame is exactly NUM_CHUNKS beats.

Test Plan:
- FRAME_WIDTH=256, num_frames=1, gap=0, store model with 4-cycle capture, out_ready=1 -> one fs_trigger pulse, 8 beats matching stored chunks 0..7, out_last on beat 8, frames_done=1, busy low after.
- FRAME_WIDTH=80, num_frames=3, gap_cycles=10, out_ready random 50% -> 3 frames of 3 beats; last chunk upper 16 bits zero; exactly 11 cycles from each last accept to next trigger; 9 rdStrobes total.
- Store model never asserts status[0], TIMEOUT_CYCLES=20 -> timeout_err=1 at cycle 21 after trigger, state IDLE, no out_valid; a following start clears timeout_err.
- num_frames=0, abort during beat 4 of frame 2 with out_ready=0 -> out_valid drops next cycle, frames_done=1, busy=0; restart yields correct frame from chunk 0.
- start and abort in the same cycle while idle -> no trigger, busy stays 0; start while busy -> ignored, num_frames unchanged.
- FRAME_HEADER_EN defined, num_frames=2 -> beats 0xF5A00000 + 8 chunks, then 0xF5A00001 + 8 chunks; no rdStrobe on header beats.
